// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the MIPS memory responder and its boot loader.
// Optional core-store counter is enabled with MIPS_MEM_WRCNT_EN (see mips_mem_responder).
package mips_mem_pkg;
  typedef enum logic [1:0] {LEN0, LEN1, DATA, RUN} boot_state_t;
  localparam int BOOT_LEN_W     = 16;
  localparam int BYTES_PER_WORD = 4;
endpackage

// File: rtl/mips_boot_loader.sv
// Boot-loader FSM: takes a 16-bit little-endian word count, then packs bytes into words
// and emits one array write per word while holding the core in reset.
//   state | meaning
//   LEN0  | waiting for len[7:0]
//   LEN1  | waiting for len[15:8]; zero length goes straight to RUN
//   DATA  | assembling words, bcnt selects the byte lane
//   RUN   | load finished, core released; terminal until reset
module mips_boot_loader
  import mips_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  localparam int ADDR_W = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              boot_valid,
  input  logic [7:0]        boot_data,
  output logic              boot_ready,
  output boot_state_t       state,
  output logic              ld_we,
  output logic [ADDR_W-1:0] ld_idx,
  output logic [31:0]       ld_wdata,
  output logic              core_reset,
  output logic              boot_done
);
  localparam int BCNT_W = $clog2(BYTES_PER_WORD);
  localparam logic [BCNT_W-1:0]     BCNT_LAST = BCNT_W'(BYTES_PER_WORD - 1);
  localparam logic [BOOT_LEN_W-1:0] LEN_ONE   = BOOT_LEN_W'(1);

  boot_state_t           state_q, state_d;
  logic [BOOT_LEN_W-1:0] len_q, len_d;
  logic [BOOT_LEN_W-1:0] widx_q, widx_d;
  logic [BCNT_W-1:0]     bcnt_q, bcnt_d;
  logic [31:0]           asm_q, asm_d;
  logic                  core_reset_q, core_reset_d;
  logic                  boot_done_q, boot_done_d;
  logic                  xfer;
  logic                  in_range;

  // Gated by rst_n so nothing is accepted while reset is held.
  assign boot_ready = rst_n & (state_q != RUN);
  assign xfer       = boot_valid & boot_ready;
  assign in_range   = ({{(32-BOOT_LEN_W){1'b0}}, widx_q} < DEPTH_WORDS);

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    widx_d  = widx_q;
    bcnt_d  = bcnt_q;
    asm_d   = asm_q;
    ld_we   = 1'b0;
    ld_idx  = widx_q[ADDR_W-1:0];
    if (xfer) begin
      case (state_q)
        LEN0: begin
          len_d[7:0] = boot_data;
          state_d    = LEN1;
        end
        LEN1: begin
          len_d[15:8] = boot_data;
          widx_d      = '0;
          bcnt_d      = '0;
          state_d     = ({boot_data, len_q[7:0]} == '0) ? RUN : DATA;
        end
        DATA: begin
          asm_d[{bcnt_q, 3'b000} +: 8] = boot_data;
          if (bcnt_q == BCNT_LAST) begin
            // Words past the array end are still consumed so the stream stays aligned.
            ld_we  = in_range;
            widx_d = widx_q + LEN_ONE;
            bcnt_d = '0;
            if (widx_q + LEN_ONE == len_q) state_d = RUN;
          end else begin
            bcnt_d = bcnt_q + BCNT_W'(1);
          end
        end
        default: ;
      endcase
    end
    ld_wdata     = asm_d;
    core_reset_d = (state_d != RUN);
    boot_done_d  = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= LEN0;
      len_q        <= '0;
      widx_q       <= '0;
      bcnt_q       <= '0;
      asm_q        <= '0;
      core_reset_q <= 1'b1;
      boot_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      widx_q       <= widx_d;
      bcnt_q       <= bcnt_d;
      asm_q        <= asm_d;
      core_reset_q <= core_reset_d;
      boot_done_q  <= boot_done_d;
    end
  end

  assign state      = state_q;
  assign core_reset = core_reset_q;
  assign boot_done  = boot_done_q;
endmodule

// File: rtl/mips_mem_responder.sv
// Unified instruction/data word array for the multicycle MIPS core, filled by the boot loader.
// Define MIPS_MEM_WRCNT_EN to add the saturating wr_count core-store counter output.
module mips_mem_responder
  import mips_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  localparam int ADDR_W = $clog2(DEPTH_WORDS)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  output logic [31:0] instr,
  input  logic [31:0] aluout,
  input  logic [31:0] writedata,
  input  logic        memwrite,
  output logic [31:0] readdata,
  input  logic        boot_valid,
  input  logic [7:0]  boot_data,
  output logic        boot_ready,
  output logic        core_reset,
  output logic        boot_done
`ifdef MIPS_MEM_WRCNT_EN
  ,
  output logic [31:0] wr_count
`endif
);
  logic [31:0]       mem_q [DEPTH_WORDS];
  logic [ADDR_W-1:0] fetch_idx, data_idx;
  boot_state_t       ld_state;
  logic              ld_we;
  logic [ADDR_W-1:0] ld_idx;
  logic [31:0]       ld_wdata;
  logic              core_we;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_idx;
  logic [31:0]       wr_data;
  logic              unused_addr;

  mips_boot_loader #(.DEPTH_WORDS(DEPTH_WORDS)) u_loader (
    .clk        (clk),
    .rst_n      (reset),
    .boot_valid (boot_valid),
    .boot_data  (boot_data),
    .boot_ready (boot_ready),
    .state      (ld_state),
    .ld_we      (ld_we),
    .ld_idx     (ld_idx),
    .ld_wdata   (ld_wdata),
    .core_reset (core_reset),
    .boot_done  (boot_done)
  );

  // Byte lanes and high bits are dropped, so addresses wrap modulo the array size.
  assign fetch_idx   = pc[ADDR_W+1:2];
  assign data_idx    = aluout[ADDR_W+1:2];
  assign unused_addr = ^{pc[31:ADDR_W+2], pc[1:0], aluout[31:ADDR_W+2], aluout[1:0]};

  assign instr    = mem_q[fetch_idx];
  assign readdata = mem_q[data_idx];

  always_comb begin
    core_we = (ld_state == RUN) & memwrite;
    wr_en   = ld_we | core_we;
    wr_idx  = (ld_state == RUN) ? data_idx : ld_idx;
    wr_data = (ld_state == RUN) ? writedata : ld_wdata;
  end

  // Array contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= wr_data;
  end

`ifdef MIPS_MEM_WRCNT_EN
  logic [31:0] wr_count_q, wr_count_d;

  always_comb begin
    wr_count_d = wr_count_q;
    if (core_we && (wr_count_q != 32'hFFFF_FFFF)) wr_count_d = wr_count_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) wr_count_q <= '0;
    else        wr_count_q <= wr_count_d;
  end

  assign wr_count = wr_count_q;
`endif
endmodule

// File: tb/tb_mips_mem_responder.sv
module tb_mips_mem_responder;
  localparam int K_INSTR = 0;
  localparam int K_RD    = 1;
  localparam int K_CRST  = 2;
  localparam int K_DONE  = 3;
  localparam int K_RDY   = 4;
  localparam int K_WRC   = 5;

  typedef struct {
    string       name;
    int          d;
    int          kind;
    logic [31:0] exp;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n     [2];
  logic [31:0] pc        [2];
  logic [31:0] aluout    [2];
  logic [31:0] writedata [2];
  logic        memwrite  [2];
  logic        bv        [2];
  logic [7:0]  bd        [2];
  logic [31:0] instr     [2];
  logic [31:0] readdata  [2];
  logic        rdy       [2];
  logic        crst      [2];
  logic        done      [2];
`ifdef MIPS_MEM_WRCNT_EN
  logic [31:0] wrc       [2];
`endif

  exp_t sbq[$];
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  mips_mem_responder #(.DEPTH_WORDS(256)) u_big (
    .clk(clk), .reset(rst_n[0]), .pc(pc[0]), .instr(instr[0]), .aluout(aluout[0]),
    .writedata(writedata[0]), .memwrite(memwrite[0]), .readdata(readdata[0]),
    .boot_valid(bv[0]), .boot_data(bd[0]), .boot_ready(rdy[0]),
    .core_reset(crst[0]), .boot_done(done[0])
`ifdef MIPS_MEM_WRCNT_EN
    , .wr_count(wrc[0])
`endif
  );

  mips_mem_responder #(.DEPTH_WORDS(4)) u_small (
    .clk(clk), .reset(rst_n[1]), .pc(pc[1]), .instr(instr[1]), .aluout(aluout[1]),
    .writedata(writedata[1]), .memwrite(memwrite[1]), .readdata(readdata[1]),
    .boot_valid(bv[1]), .boot_data(bd[1]), .boot_ready(rdy[1]),
    .core_reset(crst[1]), .boot_done(done[1])
`ifdef MIPS_MEM_WRCNT_EN
    , .wr_count(wrc[1])
`endif
  );

  function automatic logic [31:0] actual(int d, int kind);
    case (kind)
      K_INSTR: return instr[d];
      K_RD:    return readdata[d];
      K_CRST:  return {31'b0, crst[d]};
      K_DONE:  return {31'b0, done[d]};
      K_RDY:   return {31'b0, rdy[d]};
`ifdef MIPS_MEM_WRCNT_EN
      K_WRC:   return wrc[d];
`endif
      default: return 32'hDEAD_0BAD;
    endcase
  endfunction

  always @(negedge clk) begin : monitor
    exp_t        e;
    logic [31:0] act;
    while (sbq.size() > 0) begin
      e   = sbq.pop_front();
      act = actual(e.d, e.kind);
      n_total++;
      if (act === e.exp) n_pass++;
      else $display("FAIL %s: dut%0d actual=%h required=%h", e.name, e.d, act, e.exp);
    end
  end

  task automatic check_now(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%h required=%h", name, act, exp);
  endtask

  task automatic wait_done(int d, int limit, string name);
    int n;
    n = 0;
    while ((done[d] !== 1'b1) && (n < limit)) begin
      tick();
      n++;
    end
    n_total++;
    if (done[d] === 1'b1) n_pass++;
    else $display("FAIL %s: dut%0d boot_done wait expired after %0d cycles", name, d, limit);
  endtask

  task automatic push_exp(int d, int kind, logic [31:0] exp, string name);
    exp_t e;
    e.name = name; e.d = d; e.kind = kind; e.exp = exp;
    sbq.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(int d, logic [7:0] b);
    bv[d] = 1'b1;
    bd[d] = b;
    push_exp(d, K_RDY, 32'd1, "ready_while_loading");
    push_exp(d, K_CRST, 32'd1, "core_reset_while_loading");
    tick();
    bv[d] = 1'b0;
  endtask

  task automatic post_boot(int d);
    push_exp(d, K_CRST, 32'd0, "core_reset_after_load");
    push_exp(d, K_DONE, 32'd1, "boot_done_after_load");
    push_exp(d, K_RDY, 32'd0, "ready_in_run");
  endtask

  task automatic rd(int d, logic [31:0] addr, logic [31:0] exp, string name);
    aluout[d] = addr;
    pc[d]     = addr;
    push_exp(d, K_RD, exp, name);
    push_exp(d, K_INSTR, exp, name);
    tick();
  endtask

  task automatic wr(int d, logic [31:0] addr, logic [31:0] data);
    aluout[d]    = addr;
    writedata[d] = data;
    memwrite[d]  = 1'b1;
    tick();
    memwrite[d]  = 1'b0;
  endtask

  task automatic hold_reset(int d);
    rst_n[d] = 1'b0;
    push_exp(d, K_CRST, 32'd1, "rst_core_reset");
    push_exp(d, K_DONE, 32'd0, "rst_boot_done");
    push_exp(d, K_RDY, 32'd0, "rst_ready");
`ifdef MIPS_MEM_WRCNT_EN
    push_exp(d, K_WRC, 32'd0, "rst_wr_count");
`endif
    tick();
    rst_n[d] = 1'b1;
    push_exp(d, K_RDY, 32'd1, "ready_in_len0");
    push_exp(d, K_CRST, 32'd1, "core_reset_in_len0");
    tick();
  endtask

  logic [7:0] boot2 [10];
  logic [7:0] part5 [5];
  logic [7:0] boot1 [6];

  initial begin
    boot2 = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    part5 = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC};
    boot1 = '{8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00};
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; pc[d] = '0; aluout[d] = '0; writedata[d] = '0;
      memwrite[d] = 1'b0; bv[d] = 1'b0; bd[d] = '0;
    end
    tick();
    for (int d = 0; d < 2; d++) begin
      check_now("reset_state_core_reset", {31'b0, crst[d]}, 32'd1);
      check_now("reset_state_boot_done", {31'b0, done[d]}, 32'd0);
      check_now("reset_state_boot_ready", {31'b0, rdy[d]}, 32'd0);
    end
    rst_n[1] = 1'b1;
    hold_reset(0);

    for (int i = 0; i < 10; i++) send(0, boot2[i]);
    wait_done(0, 4, "boot2_done_wait");
    post_boot(0);
    rd(0, 32'h0, 32'h1234_5678, "boot_word0");
    rd(0, 32'h4, 32'hDEAD_BEEF, "boot_word1");
    rd(0, 32'h7, 32'hDEAD_BEEF, "boot_word1_lane3");

    bv[0] = 1'b1; bd[0] = 8'h55;
    push_exp(0, K_RDY, 32'd0, "ready_ignored_in_run");
    tick();
    bv[0] = 1'b0;
    rd(0, 32'h0, 32'h1234_5678, "word0_after_stray_byte");

    wr(0, 32'h10, 32'hCAFE_F00D);
    rd(0, 32'h10, 32'hCAFE_F00D, "store_readback");
    rd(0, 32'h13, 32'hCAFE_F00D, "store_readback_lane3");
    aluout[0] = 32'h10; pc[0] = 32'h10; writedata[0] = 32'h1111_1111; memwrite[0] = 1'b1;
    push_exp(0, K_RD, 32'hCAFE_F00D, "read_old_during_write");
    tick();
    memwrite[0] = 1'b0;
    rd(0, 32'h10, 32'h1111_1111, "overwrite_readback");
    wr(0, 32'h400, 32'hA5A5_A5A5);
    rd(0, 32'h0, 32'hA5A5_A5A5, "wrap_0x400_to_0");
`ifdef MIPS_MEM_WRCNT_EN
    push_exp(0, K_WRC, 32'd3, "wr_count_three");
    tick();
`endif

    hold_reset(0);
    for (int i = 0; i < 5; i++) send(0, part5[i]);
    hold_reset(0);
    memwrite[0] = 1'b1; aluout[0] = 32'h40; writedata[0] = 32'hFFFF_FFFF;
    for (int i = 0; i < 6; i++) send(0, boot1[i]);
    memwrite[0] = 1'b0;
    wait_done(0, 4, "reboot_done_wait");
    post_boot(0);
    rd(0, 32'h0, 32'h0000_0001, "reboot_word0");
`ifdef MIPS_MEM_WRCNT_EN
    push_exp(0, K_WRC, 32'd0, "wr_count_ignores_boot");
    tick();
`endif

    hold_reset(0);
    send(0, 8'h00);
    send(0, 8'h00);
    post_boot(0);
    tick();
    bv[0] = 1'b1; bd[0] = 8'hAB;
    push_exp(0, K_RDY, 32'd0, "len0_ready_low");
    push_exp(0, K_DONE, 32'd1, "len0_done_held");
    tick();
    bv[0] = 1'b0;

    memwrite[1] = 1'b1; aluout[1] = 32'h0; writedata[1] = 32'hFFFF_FFFF;
    send(1, 8'h06);
    send(1, 8'h00);
    for (int i = 0; i < 24; i++) send(1, 8'(i));
    memwrite[1] = 1'b0;
    wait_done(1, 4, "ovf_done_wait");
    post_boot(1);
    rd(1, 32'h0, 32'h0302_0100, "ovf_word0");
    rd(1, 32'h4, 32'h0706_0504, "ovf_word1");
    rd(1, 32'h8, 32'h0B0A_0908, "ovf_word2");
    rd(1, 32'hC, 32'h0F0E_0D0C, "ovf_word3");
`ifdef MIPS_MEM_WRCNT_EN
    push_exp(1, K_WRC, 32'd0, "ovf_wr_count_zero");
`endif

    tick();
    tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/mips_mem_responder.md
Name: mips_mem_responder

Overview:
- Memory-side responder for the multicycle MIPS core: serves the core's `pc`/`instr` fetch and `aluout`/`writedata`/`readdata`/`memwrite` data accesses from a single unified word array.
- Contains a boot-loader FSM that fills the array from a byte stream while holding the core in reset, then releases the core.
- Sits beside the core in the top level and replaces any static program ROM.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words in the array; must be a power of two.
- ADDR_W, $clog2(DEPTH_WORDS), word-index width (derived, not overridden).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- pc  input  32  instruction fetch byte address from core.
- instr  output  32  word at pc.
- aluout  input  32  data byte address from core.
- writedata  input  32  store data from core.
- memwrite  input  1  store strobe from core.
- readdata  output  32  word at aluout.
- boot_valid  input  1  boot byte available.
- boot_data  input  8  boot byte.
- boot_ready  output  1  responder accepts the byte this cycle.
- core_reset  output  1  active-high reset to core; high until load completes.
- boot_done  output  1  high in RUN state.

Behaviour:
- Word index:
  - Fetch index is pc[ADDR_W+1:2]; data index is aluout[ADDR_W+1:2].
  - Bits [1:0] are ignored; upper bits are ignored, so addresses wrap modulo DEPTH_WORDS.
- Reads are combinational from the array: instr and readdata follow the address inputs in the same cycle. Both are valid in every state.
- Core writes:
  - In RUN, memwrite=1 writes writedata to the data index at the clock edge.
  - A read of the same index in that cycle returns the old value.
  - memwrite is ignored in every other state.
- FSM states: LEN0, LEN1, DATA, RUN. Reset value is LEN0.
- Byte transfer: a byte transfers when boot_valid & boot_ready.
- boot_ready:
  - 1 in LEN0, LEN1 and DATA.
  - 0 in RUN.
  - 0 during reset.
- LEN0: capture boot_data into len[7:0], go to LEN1.
- LEN1:
  - Capture len[15:8].
  - If the full 16-bit len is 0, go to RUN; otherwise go to DATA with widx=0 and bcnt=0.
- DATA:
  - Bytes are little-endian: bcnt 0..3 fills bits [7:0]..[31:24] of the assembly register.
  - On the byte with bcnt=3, the assembled word is written to index widx[ADDR_W-1:0], but only if widx < DEPTH_WORDS. Words beyond DEPTH_WORDS are consumed and discarded.
  - Then widx increments and bcnt returns to 0.
  - When widx+1 == len on that byte, go to RUN.
- RUN:
  - Terminal until reset.
  - core_reset=0 and boot_done=1, registered, asserting the cycle after the RUN transition.
  - Stalled boot_valid=0 cycles in any load state hold all state.
- Reset values: core_reset=1, boot_done=0, boot_ready=0, len=0, widx=0, bcnt=0, assembly register 0.
- Array contents are not reset; unloaded words are undefined.
- Reset mid-load returns to LEN0. Previously written words are retained but are not guaranteed.

Optional Feature:
- Macro MIPS_MEM_WRCNT_EN.
- Defined: adds output wr_count (32 bits, reset 0).
  - Increments on each accepted core write in RUN.
  - Saturates at 32'hFFFF_FFFF.
  - Boot-loader writes are not counted.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package mips_mem_pkg holds:
  - boot_state_t enum {LEN0, LEN1, DATA, RUN};
  - localparam BOOT_LEN_W=16;
  - localparam BYTES_PER_WORD=4.
- One natural sub-module, mips_boot_loader:
  - contains the FSM, byte assembly and word counter;
  - outputs a write-enable/index/data triple plus core_reset and boot_done.
- The top muxes loader writes versus core writes on FSM state.

Test Plan:
- Boot 2 words (bytes 02 00 78 56 34 12 EF BE AD DE) -> word0=32'h12345678, word1=32'hDEADBEEF; core_reset falls the cycle after the last byte; boot_done=1.
- len=0 (bytes 00 00) -> RUN after 2 bytes; boot_ready=0 thereafter; further boot_valid is ignored.
- After boot: memwrite=1, aluout=32'h0000_0010, writedata=32'hCAFEF00D -> next cycle readdata=32'hCAFEF00D at aluout=0x10; instr=32'hCAFEF00D at pc=0x10; aluout=0x13 reads the same word.
- Wrap: with DEPTH_WORDS=256, write at aluout=0x400 -> readable at aluout=0x000.
- Overflow boot with DEPTH_WORDS=4, len=6 -> all 26 bytes accepted; words 4 and 5 are discarded; words 0..3 are correct; RUN is reached.
- Assert reset mid-DATA (after 5 bytes), release, reboot 1 word 32'h00000001 -> word0=1; core_reset=1 until the new load completes.
- With MIPS_MEM_WRCNT_EN: 3 core stores -> wr_count=3; memwrite held during boot -> wr_count stays 0.
